// File: rtl/clken_manager.sv
// clken_manager
//   Sits behind the board PLL on the single fabric clock. It qualifies the PLL
//   lock through a 2-FF synchroniser and a debounce count, then sequences the
//   core reset release. It also generates NUM_CH phase-aligned fractional
//   clock enables. Each enable averages NUM/DEN, and any channel can be
//   bypassed so that it is held high.
//
// Ports
//   clkin      in   fabric clock (PLL output)
//   reset_n    in   asynchronous active-low reset
//   lock_in    in   PLL lock, asynchronous to clkin
//   clken      out  [NUM_CH] one-cycle-wide clock enables
//   rst_out_n  out  synchronous active-low core reset
//   ready      out  high in RUN
//   lost_cnt   out  [8] lock losses seen while in RUN, saturating at 255
//   state      out  [2] FSM state, for debug
//
// state     | meaning
// WAIT_LOCK | no lock; enables off, core held in reset
// STABLE    | lock seen; debouncing for LOCK_STABLE cycles
// HOLD      | enables running, core still in reset for RST_HOLD cycles
// RUN       | core out of reset, ready high
module clken_manager #(
  parameter int                         NUM_CH      = 3,
  parameter int                         ACC_W       = 16,
  parameter logic [NUM_CH*ACC_W-1:0]    NUM_VEC     = {16'd1, 16'd1, 16'd1},
  parameter logic [NUM_CH*ACC_W-1:0]    DEN_VEC     = {16'd4, 16'd2, 16'd6},
  parameter logic [NUM_CH-1:0]          BYPASS_MASK = '0,
  parameter int                         LOCK_STABLE = 1024,
  parameter int                         RST_HOLD    = 16
) (
  input  logic              clkin,
  input  logic              reset_n,
  input  logic              lock_in,
  output logic [NUM_CH-1:0] clken,
  output logic              rst_out_n,
  output logic              ready,
  output logic [7:0]        lost_cnt,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int CNT_MAX = (LOCK_STABLE > RST_HOLD) ? LOCK_STABLE : RST_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // The timer counts down to zero. These preloads give exactly LOCK_STABLE
  // debounce edges and RST_HOLD hold cycles.
  localparam logic [CNT_W-1:0] STABLE_LOAD = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(RST_HOLD - 1);

  logic              r_sync1;
  logic              r_lock_s;
  state_t            r_state;
  logic [CNT_W-1:0]  r_timer;
  logic              r_rst_out_n;
  logic              r_ready;
  logic [7:0]        r_lost_cnt;
  logic [NUM_CH-1:0] r_clken;
  logic [ACC_W-1:0]  r_acc [NUM_CH];

  logic              w_active;
  logic              w_enter_hold;
  logic [ACC_W:0]    w_sum  [NUM_CH];
  logic [ACC_W-1:0]  w_rem  [NUM_CH];
  logic [NUM_CH-1:0] w_wrap;

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= lock_in;
      r_lock_s <= r_sync1;
    end
  end

  // Lock loss is checked first, so it overrides every other transition.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= WAIT_LOCK;
      r_timer     <= '0;
      r_rst_out_n <= 1'b0;
      r_ready     <= 1'b0;
      r_lost_cnt  <= '0;
    end else if (r_state != WAIT_LOCK && !r_lock_s) begin
      r_state     <= WAIT_LOCK;
      r_timer     <= '0;
      r_rst_out_n <= 1'b0;
      r_ready     <= 1'b0;
      if (r_state == RUN && r_lost_cnt != 8'hFF)
        r_lost_cnt <= r_lost_cnt + 8'd1;
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          r_timer <= '0;
          if (r_lock_s) begin
            r_state <= STABLE;
            r_timer <= STABLE_LOAD;
          end
        end
        STABLE: begin
          if (r_timer == '0) begin
            r_state <= HOLD;
            r_timer <= HOLD_LOAD;
          end else begin
            r_timer <= r_timer - CNT_W'(1);
          end
        end
        HOLD: begin
          if (r_timer == '0) begin
            r_state     <= RUN;
            r_rst_out_n <= 1'b1;
            r_ready     <= 1'b1;
          end else begin
            r_timer <= r_timer - CNT_W'(1);
          end
        end
        RUN: begin
          r_timer <= '0;
        end
        default: begin
          r_state <= WAIT_LOCK;
          r_timer <= '0;
        end
      endcase
    end
  end

  // The sum carries one extra bit, so NUM close to 2^ACC_W cannot overflow
  // before the compare. The remainder is always below DEN, so it fits in
  // ACC_W bits.
  always_comb begin
    w_active     = r_lock_s && (r_state == HOLD || r_state == RUN);
    w_enter_hold = r_lock_s && (r_state == STABLE) && (r_timer == '0);
    w_wrap       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_sum[i]  = {1'b0, r_acc[i]} + {1'b0, NUM_VEC[i*ACC_W +: ACC_W]};
      w_wrap[i] = (w_sum[i] >= {1'b0, DEN_VEC[i*ACC_W +: ACC_W]});
      w_rem[i]  = w_sum[i][ACC_W-1:0] - DEN_VEC[i*ACC_W +: ACC_W];
    end
  end

  // The accumulators are zero outside HOLD/RUN. All channels therefore start
  // the same phase on the edge that enters HOLD.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      r_clken <= '0;
      for (int i = 0; i < NUM_CH; i++) r_acc[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_active) begin
          if (BYPASS_MASK[i]) begin
            r_clken[i] <= 1'b1;
            r_acc[i]   <= '0;
          end else if (w_wrap[i]) begin
            r_clken[i] <= 1'b1;
            r_acc[i]   <= w_rem[i];
          end else begin
            r_clken[i] <= 1'b0;
            r_acc[i]   <= w_sum[i][ACC_W-1:0];
          end
        end else begin
          r_acc[i]   <= '0;
          r_clken[i] <= BYPASS_MASK[i] & w_enter_hold;
        end
      end
    end
  end

  assign clken     = r_clken;
  assign rst_out_n = r_rst_out_n;
  assign ready     = r_ready;
  assign lost_cnt  = r_lost_cnt;
  assign state     = r_state;

endmodule

// File: tb/tb_clken_manager.sv
// Self-checking bench for clken_manager.
// Configuration: LOCK_STABLE=8, RST_HOLD=4.
//   ch0 runs at 1/4, ch1 is bypassed, ch2 runs at 3/8.
// The reference model tracks L, the number of consecutive edges at which the
// synchronised lock was high. All expected outputs are derived from L:
//   L = 0              -> state 0
//   L in 1..LS         -> state 1
//   L in LS+1..LS+RH   -> state 2
//   L > LS+RH          -> state 3
// In HOLD/RUN, h = L-LS-1 counts the cycles since HOLD entry. A channel
// pulses when floor(h*N/D) increments.
module tb_clken_manager;
  localparam int LS     = 8;
  localparam int RH     = 4;
  localparam int HOLD_L = LS + 1;
  localparam int RUN_L  = LS + RH + 1;

  logic       clkin = 1'b0;
  logic       reset_n;
  logic       lock_in;
  logic [2:0] clken;
  logic       rst_out_n;
  logic       ready;
  logic [7:0] lost_cnt;
  logic [1:0] state;

  int n_chk  = 0;
  int n_fail = 0;

  clken_manager #(
    .NUM_CH      (3),
    .ACC_W       (16),
    .NUM_VEC     ({16'd3, 16'd1, 16'd1}),
    .DEN_VEC     ({16'd8, 16'd2, 16'd4}),
    .BYPASS_MASK (3'b010),
    .LOCK_STABLE (LS),
    .RST_HOLD    (RH)
  ) dut (
    .clkin     (clkin),
    .reset_n   (reset_n),
    .lock_in   (lock_in),
    .clken     (clken),
    .rst_out_n (rst_out_n),
    .ready     (ready),
    .lost_cnt  (lost_cnt),
    .state     (state)
  );

  always #5 clkin = ~clkin;

  // ---------------- reference model ----------------
  int m_num [3] = '{1, 1, 3};
  int m_den [3] = '{4, 2, 8};
  bit m_byp [3] = '{0, 1, 0};
  int m_L    = 0;
  int m_lost = 0;
  bit m_s1   = 0;
  bit m_ls   = 0;

  always @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      m_L = 0; m_lost = 0; m_s1 = 0; m_ls = 0;
    end else begin
      if (m_ls) begin
        if (m_L < 1000000) m_L = m_L + 1;
      end else begin
        if (m_L >= RUN_L && m_lost < 255) m_lost = m_lost + 1;
        m_L = 0;
      end
      m_ls = m_s1;
      m_s1 = lock_in;
    end
  end

  function automatic logic [1:0] exp_state(input int L);
    if (L == 0)            return 2'd0;
    else if (L < HOLD_L)   return 2'd1;
    else if (L < RUN_L)    return 2'd2;
    else                   return 2'd3;
  endfunction

  function automatic logic [2:0] exp_clken(input int L);
    logic [2:0] r;
    longint h;
    r = '0;
    if (L >= HOLD_L) begin
      h = L - HOLD_L;
      for (int c = 0; c < 3; c++) begin
        if (m_byp[c]) r[c] = 1'b1;
        else if (h > 0)
          r[c] = ((h * m_num[c]) / m_den[c]) != (((h - 1) * m_num[c]) / m_den[c]);
      end
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clkin) begin
    chk("m_state",  32'(state),     32'(exp_state(m_L)));
    chk("m_clken",  32'(clken),     32'(exp_clken(m_L)));
    chk("m_rst",    32'(rst_out_n), 32'(m_L >= RUN_L));
    chk("m_ready",  32'(ready),     32'(m_L >= RUN_L));
    chk("m_lost",   32'(lost_cnt),  32'(m_lost));
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clkin);
      #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int c0, c1, c2, adj;
    logic p2;
    reset_n = 1'b0;
    lock_in = 1'b0;
    step(3);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_clken", 32'(clken), 32'd0);
    chk("rst_rstn",  32'(rst_out_n), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_lost",  32'(lost_cnt), 32'd0);
    reset_n = 1'b1;
    step(2);

    // Power-up: lock_in rises at edge 0.
    lock_in = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step(1);
      if (e == 2)  chk("pu_e2_state", 32'(state), 32'd0);
      if (e == 3)  chk("pu_e3_state", 32'(state), 32'd1);
      if (e == 10) begin
        chk("pu_e10_state", 32'(state), 32'd1);
        chk("pu_e10_clken", 32'(clken), 32'd0);
      end
      if (e == 11) begin
        chk("pu_e11_state", 32'(state), 32'd2);
        chk("pu_e11_byp",   32'(clken[1]), 32'd1);
        chk("pu_e11_ch0",   32'(clken[0]), 32'd0);
      end
      if (e == 14) chk("pu_e14_rstn", 32'(rst_out_n), 32'd0);
      if (e == 15) begin
        chk("pu_e15_rstn",  32'(rst_out_n), 32'd1);
        chk("pu_e15_ready", 32'(ready), 32'd1);
        chk("pu_e15_state", 32'(state), 32'd3);
        chk("pu_e15_ch0",   32'(clken[0]), 32'd1);
      end
      if (e == 16) chk("pu_e16_ch0", 32'(clken[0]), 32'd0);
      if (e == 19) chk("pu_e19_ch0", 32'(clken[0]), 32'd1);
    end

    // Pulse counts in RUN.
    c0 = 0; c1 = 0; c2 = 0; adj = 0; p2 = 1'b0;
    for (int k = 0; k < 800; k++) begin
      step(1);
      if (k < 400 && clken[0]) c0++;
      if (clken[1]) c1++;
      if (clken[2]) begin
        c2++;
        if (p2) adj++;
      end
      p2 = clken[2];
    end
    chk("cnt_ch0_400", 32'(c0), 32'd100);
    chk("cnt_ch1_800", 32'(c1), 32'd800);
    chk("cnt_ch2_800", 32'(c2), 32'd300);
    chk("ch2_adjacent", 32'(adj), 32'd0);

    // Lock loss in RUN.
    lock_in = 1'b0;
    step(2);
    chk("loss_e2_rstn", 32'(rst_out_n), 32'd1);
    step(1);
    chk("loss_e3_rstn",  32'(rst_out_n), 32'd0);
    chk("loss_e3_ready", 32'(ready), 32'd0);
    chk("loss_e3_clken", 32'(clken), 32'd0);
    chk("loss_e3_lost",  32'(lost_cnt), 32'd1);
    chk("loss_e3_state", 32'(state), 32'd0);
    step(3);

    // Async reset mid-HOLD.
    lock_in = 1'b1;
    step(12);
    chk("hold_state", 32'(state), 32'd2);
    reset_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_clken", 32'(clken), 32'd0);
    chk("arst_rstn",  32'(rst_out_n), 32'd0);
    chk("arst_lost",  32'(lost_cnt), 32'd0);
    reset_n = 1'b1;
    step(14);
    chk("rel_e14_rstn", 32'(rst_out_n), 32'd0);
    step(1);
    chk("rel_e15_rstn", 32'(rst_out_n), 32'd1);

    // Lock glitch during STABLE restarts the debounce.
    reset_n = 1'b0;
    lock_in = 1'b0;
    #1;
    reset_n = 1'b1;
    step(3);
    lock_in = 1'b1;
    step(6);
    lock_in = 1'b0;
    step(2);
    chk("gl_e8_state", 32'(state), 32'd1);
    step(1);
    chk("gl_e9_state", 32'(state), 32'd0);
    step(2);
    lock_in = 1'b1;
    step(14);
    chk("gl_re14_rstn",  32'(rst_out_n), 32'd0);
    chk("gl_re14_state", 32'(state), 32'd2);
    step(1);
    chk("gl_re15_rstn", 32'(rst_out_n), 32'd1);
    chk("gl_lost",      32'(lost_cnt), 32'd0);

    // 300 forced losses from RUN.
    for (int i = 0; i < 300; i++) begin
      lock_in = 1'b0;
      step(4);
      chk("lost_sat", 32'(lost_cnt), 32'((i + 1 < 255) ? i + 1 : 255));
      lock_in = 1'b1;
      step(16);
    end
    chk("lost_final", 32'(lost_cnt), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
